// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front-end for the synchronous instruction ROM.
// Owns the fetch PC and tracks the single outstanding ROM read. Returned words
// land in a 2-entry FIFO that decode drains with a valid/ready handshake.
// A redirect flushes the in-flight read and the buffer, then fetch restarts.
// Optional feature macro: IFETCH_MISALIGN_EN (adds sticky misalign_err output).
module instr_fetch #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic                  misalign_err
`endif
);

  logic [31:0]           r_fetch_pc;
  logic [31:0]           r_issue_pc;
  logic                  r_inflight;
  logic [1:0]            r_count;
  logic [31:0]           r_buf_pc   [2];
  logic [DATA_WIDTH-1:0] r_buf_data [2];

  logic                  w_pop;
  logic                  w_push;
  logic                  w_miss;
  logic                  w_halt;
  logic [2:0]            w_occ;
  logic                  w_issue;

  // Entry 0 is always the head, so outputs come straight from registers.
  assign instr_valid = (r_count != 2'd0);
  assign instr       = r_buf_data[0];
  assign instr_pc    = r_buf_pc[0];
  assign rom_addr    = r_fetch_pc[ADDR_WIDTH+1:2];

  assign w_pop  = instr_valid & instr_ready;
  assign w_push = r_inflight & rom_rdata_valid;
  assign w_miss = r_inflight & ~rom_rdata_valid;
  // Occupancy counts the word still on its way so the buffer never overflows.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  // A miss rewinds fetch_pc this cycle, so issuing the advanced PC now would
  // put a younger word ahead of the refetched one.
  assign w_issue = ~redirect_valid & ~w_miss & ~w_halt & (w_occ < 3'd2);

`ifdef IFETCH_MISALIGN_EN
  logic r_misalign;

  // Sticky flag on a misaligned redirect target; it stops all further issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign w_halt       = r_misalign;
  assign misalign_err = r_misalign;
`else
  logic w_unused_lsb;

  // Low target bits are simply dropped when the check is not built in.
  assign w_halt       = 1'b0;
  assign w_unused_lsb = ^redirect_pc[1:0];
`endif

  // Fetch PC, issued-read tracking: redirect first, then miss rewind, then issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_issue_pc <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_miss) begin
        r_fetch_pc <= r_issue_pc;
      end else if (w_issue) begin
        r_issue_pc <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  // Two-entry FIFO that shifts toward entry 0 on a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= 2'd0;
      r_buf_pc[0]   <= '0;
      r_buf_pc[1]   <= '0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_buf_pc[0]   <= r_issue_pc;
            r_buf_data[0] <= rom_rdata;
          end else begin
            r_buf_pc[1]   <= r_issue_pc;
            r_buf_data[1] <= rom_rdata;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf_pc[0]   <= r_buf_pc[1];
          r_buf_data[0] <= r_buf_data[1];
          r_count       <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_buf_pc[0]   <= r_issue_pc;
            r_buf_data[0] <= rom_rdata;
          end else begin
            r_buf_pc[0]   <= r_buf_pc[1];
            r_buf_data[0] <= r_buf_data[1];
            r_buf_pc[1]   <= r_issue_pc;
            r_buf_data[1] <= rom_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. The driver keeps a queue
// of the instruction stream decode should see (PC sequence from the last
// reset/redirect, ROM word k = 0x1000+k); a monitor pops it on every handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic        rom_rdata_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFETCH_MISALIGN_EN
  logic        misalign_err;
`endif

  instr_fetch #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .rom_addr        (rom_addr),
    .rom_rdata       (rom_rdata),
    .rom_rdata_valid (rom_rdata_valid),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
`ifdef IFETCH_MISALIGN_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word k holds 0x1000+k; garbage when flagged invalid.
  logic [31:0] rom_q;
  always @(posedge clk) rom_q <= 32'h1000 + {22'd0, rom_addr};
  assign rom_rdata = rom_rdata_valid ? rom_q : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          hs_count = 0;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000 + {22'd0, pc[11:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic top_up();
    exp_t e;
    while (exp_q.size() < 6) begin
      e.pc   = model_pc;
      e.data = word_of(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Drive one cycle of inputs just after a rising edge.
  task automatic step(input logic rdy, input logic rv, input logic rd, input logic [31:0] tgt);
    exp_t keep;
    bit   taken;
    @(posedge clk);
    #1;
    instr_ready     = rdy;
    rom_rdata_valid = rv;
    redirect_valid  = rd;
    redirect_pc     = tgt;
    if (rd) begin
      // A handshake in the redirect cycle still delivers the current head.
      taken = instr_valid && rdy;
      if (taken) keep = exp_q[0];
      exp_q.delete();
      if (taken) exp_q.push_back(keep);
      model_pc = {tgt[31:2], 2'b00};
    end
    top_up();
  endtask

  task automatic redirect_and_check(input logic rdy, input logic [31:0] tgt, input string tag);
    step(rdy, 1'b1, 1'b1, tgt);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check({tag, "_flush"}, {31'd0, instr_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check({tag, "_edge1"}, {31'd0, instr_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check({tag, "_edge2_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, instr_pc, {tgt[31:2], 2'b00});
    check({tag, "_data"}, instr, word_of(tgt));
  endtask

  // Monitor: every handshake must match the head of the expected stream.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && instr_valid && instr_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: got pc %h with nothing expected", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_instr", instr, e.data);
        $display("handshake pc=%h instr=%h", instr_pc, instr);
      end
    end
  end

  initial begin : main
    logic [31:0] t;
    logic        rdy, rv, rd;
    int          hs_before;

    reset           = 1'b1;
    instr_ready     = 1'b1;
    rom_rdata_valid = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    model_pc        = 32'h0;
    top_up();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_addr", {22'd0, rom_addr}, 32'd0);

    // Release and two-edge latency, then gap-free streaming
    @(posedge clk); #1; reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check("lat_edge1", {31'd0, instr_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check("lat_edge2", {31'd0, instr_valid}, 32'd1);
    check("first_pc", instr_pc, 32'h0);
    check("first_instr", instr, 32'h1000);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk); check("stream_gapfree", {31'd0, instr_valid}, 32'd1);
    end

    // Stall for 5 cycles: head holds, issue stops two words ahead
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_pc", instr_pc, exp_q[0].pc);
    end
    t = exp_q[0].pc + 32'd8;
    check("stall_addr", {22'd0, rom_addr}, {22'd0, t[11:2]});
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk); check("resume_gapfree", {31'd0, instr_valid}, 32'd1);
    end

    // Redirect while the buffer is full
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    redirect_and_check(1'b0, 32'h40, "redir_full");
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect and handshake in the same cycle
    redirect_and_check(1'b1, 32'h100, "redir_hs");
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // One-cycle ROM miss mid-stream; scoreboard catches skips or repeats
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // ROM address wrap and 32-bit PC wrap
    redirect_and_check(1'b1, 32'hFFC, "wrap_rom");
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("wrap_rom_next_pc", instr_pc, 32'h1000);
    check("wrap_rom_next_instr", instr, 32'h1000);
    redirect_and_check(1'b1, 32'hFFFF_FFFC, "wrap_pc");
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("wrap_pc_next_pc", instr_pc, 32'h0);
    check("wrap_pc_next_instr", instr, 32'h1000);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset asserted mid-stream
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    model_pc = 32'h0;
    top_up();
    @(negedge clk);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_addr", {22'd0, rom_addr}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomised traffic
    hs_before = hs_count;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom % 4) != 0;
      rv  = ($urandom % 8) != 0;
      rd  = ($urandom % 20) == 0;
      t   = $urandom;
      if (($urandom % 2) != 0) t = t & 32'h0000_0FFF;
`ifdef IFETCH_MISALIGN_EN
      t[1:0] = 2'b00;
`endif
      step(rdy, rv, rd, t);
    end
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("random_progress", {31'd0, (hs_count - hs_before) > 500}, 32'd1);

`ifdef IFETCH_MISALIGN_EN
    // Misaligned redirect sets the sticky flag and halts fetch
    step(1'b1, 1'b1, 1'b1, 32'h42);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check("misalign_err", {31'd0, misalign_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk); check("misalign_halt", {31'd0, instr_valid}, 32'd0);
    end
    check("misalign_addr", {22'd0, rom_addr}, 32'h10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
